// File: rtl/qbus_pkg.sv
// Shared Q-bus definitions: interrupt-cycle FSM encoding, default vector width
// and the synchroniser/latency constants the interrupt logic is built around.
package qbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VEC  = 2'd1,
        ST_REL  = 2'd2,
        ST_PASS = 2'd3
    } qbus_state_t;

    localparam int QBUS_VW          = 9;
    localparam int QBUS_SYNC_STAGES = 2;
    // IAKI rising edge to DAL enable / RPLY, counted in clk edges
    localparam int QBUS_VEC_LAT     = QBUS_SYNC_STAGES + 1;
    localparam int QBUS_RPLY_LAT    = QBUS_SYNC_STAGES + 2;

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchroniser for asynchronous Q-bus control lines, cleared by reset.
module bus_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // NOTE: flops use non-blocking assignment so r_sync takes the old r_meta,
    // giving two real stages instead of collapsing into one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/bus_int_arb.sv
// Q-bus interrupt arbiter: latches per-source requests onto one BIRQ, and on the
// IAK daisy chain returns the highest-priority vector with RPLY or passes IAKO on.
module bus_int_arb
    import qbus_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int VW   = QBUS_VW
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NSRC-1:0]   ena_i,
    input  logic [NSRC-1:0]   req_i,
    input  logic [NSRC*VW-1:0] vec_i,
    input  logic              din_i,
    input  logic              iaki_i,
    output logic              irq_o,
    output logic              iako_o,
    output logic [VW-1:0]     vec_o,
    output logic              vec_oe_o,
    output logic              rply_o,
    output logic [NSRC-1:0]   ack_o
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    // Lowest index wins; scanning downward leaves the lowest set bit last.
    function automatic logic [IW-1:0] prio_enc(input logic [NSRC-1:0] p);
        prio_enc = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (p[k]) prio_enc = IW'(k);
        end
    endfunction

    qbus_state_t     r_state, w_state_nxt;
    logic [NSRC-1:0] r_pending, w_pending_nxt;
    logic [NSRC-1:0] r_ack, w_ack_nxt;
    logic [IW-1:0]   r_win, w_win_nxt, w_win;
    logic [VW-1:0]   r_vec, w_vec_nxt;
    logic            r_irq, w_irq_nxt;
    logic            r_iako, w_iako_nxt;
    logic            r_vec_oe, w_vec_oe_nxt;
    logic            r_rply, w_rply_nxt;
    logic            w_din_s, w_iaki_s;
    logic [VW-1:0]   w_vec_arr [NSRC];

    bus_sync2 u_sync_din (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (din_i),
        .q_o     (w_din_s)
    );

    bus_sync2 u_sync_iaki (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (iaki_i),
        .q_o     (w_iaki_s)
    );

    for (genvar g = 0; g < NSRC; g++) begin : g_vec
        assign w_vec_arr[g] = vec_i[g*VW +: VW];
    end

    assign w_win = prio_enc(r_pending);

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_vec_nxt   = r_vec;
        w_ack_nxt   = '0;
        // Acked bits clear, but a request in the same cycle re-arms them.
        w_pending_nxt = ((r_pending & ~r_ack) | (req_i & ena_i)) & ena_i;

        case (r_state)
            ST_IDLE: begin
                if (w_iaki_s && w_din_s) begin
                    if (|r_pending) begin
                        w_state_nxt = ST_VEC;
                        w_win_nxt   = w_win;
                        w_vec_nxt   = w_vec_arr[w_win];
                    end else begin
                        w_state_nxt = ST_PASS;
                    end
                end
            end
            ST_VEC: begin
                if (!w_din_s) begin
                    w_state_nxt = ST_REL;
                    // A source disabled mid-cycle still gets its vector read, but no ack.
                    w_ack_nxt   = ena_i & (NSRC'(1) << r_win);
                end
            end
            ST_REL: begin
                if (!w_iaki_s) w_state_nxt = ST_IDLE;
            end
            ST_PASS: begin
                if (!w_iaki_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_vec_oe_nxt = (w_state_nxt == ST_VEC);
        w_rply_nxt   = (r_state == ST_VEC) && (w_state_nxt == ST_VEC);
        w_iako_nxt   = (w_state_nxt == ST_PASS);
        w_irq_nxt    = (w_state_nxt == ST_IDLE) && (|w_pending_nxt);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_ack     <= '0;
            r_win     <= '0;
            r_vec     <= '0;
            r_irq     <= 1'b0;
            r_iako    <= 1'b0;
            r_vec_oe  <= 1'b0;
            r_rply    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_ack     <= w_ack_nxt;
            r_win     <= w_win_nxt;
            r_vec     <= w_vec_nxt;
            r_irq     <= w_irq_nxt;
            r_iako    <= w_iako_nxt;
            r_vec_oe  <= w_vec_oe_nxt;
            r_rply    <= w_rply_nxt;
        end
    end

    assign irq_o    = r_irq;
    assign iako_o   = r_iako;
    assign vec_o    = r_vec;
    assign vec_oe_o = r_vec_oe;
    assign rply_o   = r_rply;
    assign ack_o    = r_ack;

endmodule

// File: tb/tb_bus_int_arb.sv
// Self-checking bench for bus_int_arb: directed IAK scenarios plus randomized
// request/enable traffic against a transaction-level model of pending requests.
module tb_bus_int_arb;
    import qbus_pkg::*;

    localparam int NSRC = 2;
    localparam int VW   = QBUS_VW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NSRC-1:0]      ena;
    logic [NSRC-1:0]      req;
    logic [NSRC*VW-1:0]   vec;
    logic                 din;
    logic                 iaki;
    logic                 irq;
    logic                 iako;
    logic [VW-1:0]        vec_out;
    logic                 vec_oe;
    logic                 rply;
    logic [NSRC-1:0]      ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [NSRC-1:0] m_pend;
    logic [NSRC-1:0] m_ack_now;
    logic [VW-1:0]   m_vec [NSRC];

    bus_int_arb #(.NSRC(NSRC), .VW(VW)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .ena_i    (ena),
        .req_i    (req),
        .vec_i    (vec),
        .din_i    (din),
        .iaki_i   (iaki),
        .irq_o    (irq),
        .iako_o   (iako),
        .vec_o    (vec_out),
        .vec_oe_o (vec_oe),
        .rply_o   (rply),
        .ack_o    (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [NSRC-1:0] p);
        for (int k = 0; k < NSRC; k++) begin
            if (p[k]) return k;
        end
        return 0;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [6:0] hi;
        hi = 7'($urandom_range(0, 127));
        return {hi, 2'b00};
    endfunction

    task automatic set_vec(input int k, input logic [VW-1:0] v);
        m_vec[k] = v;
        vec = {m_vec[1], m_vec[0]};
    endtask

    // One clock: the model applies the request rules at the edge, then we move to the negedge.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < NSRC; k++) begin
            if (!ena[k])                 m_pend[k] = 1'b0;
            else if (req[k])             m_pend[k] = 1'b1;
            else if (m_ack_now[k])       m_pend[k] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic tick(input logic [NSRC-1:0] r);
        req = r;
        step();
        req = '0;
        chk("irq_tick", 32'(irq), 32'(|m_pend));
    endtask

    // Full interrupt-acknowledge transaction; req_at_ack is pulsed in the ack cycle.
    task automatic iak(input logic [NSRC-1:0] req_at_ack);
        logic          has;
        int            win;
        logic [VW-1:0] ev;
        has = |m_pend;
        win = lowest(m_pend);
        ev  = has ? m_vec[win[0]] : '0;
        din  = 1'b1;
        iaki = 1'b1;
        repeat (QBUS_VEC_LAT - 1) step();
        chk("irq_pre_iak", 32'(irq), 32'(has));
        chk("oe_pre", 32'(vec_oe), 32'(0));
        chk("iako_pre", 32'(iako), 32'(0));
        step();
        chk("irq_in_iak", 32'(irq), 32'(0));
        if (has) begin
            chk("oe_at_lat", 32'(vec_oe), 32'(1));
            chk("vec_at_lat", 32'(vec_out), 32'(ev));
            chk("rply_early", 32'(rply), 32'(0));
            chk("iako_vec", 32'(iako), 32'(0));
            set_vec(0, rand_vec());
            set_vec(1, rand_vec());
            repeat (QBUS_RPLY_LAT - QBUS_VEC_LAT) step();
            chk("rply_at_lat", 32'(rply), 32'(1));
            chk("vec_frozen", 32'(vec_out), 32'(ev));
            din = 1'b0;
            repeat (QBUS_SYNC_STAGES) step();
            chk("rply_hold", 32'(rply), 32'(1));
            step();
            m_ack_now = ena[win[0]] ? NSRC'(1 << win) : '0;
            chk("rply_rel", 32'(rply), 32'(0));
            chk("oe_rel", 32'(vec_oe), 32'(0));
            chk("ack_rel", 32'(ack), 32'(m_ack_now));
            req  = req_at_ack;
            iaki = 1'b0;
            step();
            req       = '0;
            m_ack_now = '0;
            chk("ack_pulse_end", 32'(ack), 32'(0));
            repeat (QBUS_SYNC_STAGES - 1) step();
            chk("irq_rel", 32'(irq), 32'(0));
            step();
            chk("irq_idle", 32'(irq), 32'(|m_pend));
        end else begin
            chk("iako_at_lat", 32'(iako), 32'(1));
            chk("oe_pass", 32'(vec_oe), 32'(0));
            din  = 1'b0;
            iaki = 1'b0;
            repeat (QBUS_SYNC_STAGES) step();
            chk("iako_hold", 32'(iako), 32'(1));
            step();
            chk("iako_drop", 32'(iako), 32'(0));
            chk("irq_after_pass", 32'(irq), 32'(|m_pend));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = '0;
        req       = '0;
        din       = 1'b0;
        iaki      = 1'b0;
        m_pend    = '0;
        m_ack_now = '0;
        set_vec(0, '0);
        set_vec(1, '0);
        #12;
        chk("rst_irq", 32'(irq), 32'(0));
        chk("rst_iako", 32'(iako), 32'(0));
        chk("rst_vec", 32'(vec_out), 32'(0));
        chk("rst_oe", 32'(vec_oe), 32'(0));
        chk("rst_rply", 32'(rply), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single source 1 request
        ena = 2'b11;
        set_vec(1, 9'o124);
        tick(2'b10);
        iak('0);

        // Both at once: source 0 first, then source 1
        set_vec(0, 9'o120);
        set_vec(1, 9'o124);
        tick(2'b11);
        iak('0);
        chk("irq_second", 32'(irq), 32'(1));
        iak('0);

        // Nothing pending: grant passes downstream
        tick('0);
        iak('0);

        // Enable dropped before IAK clears the request
        tick(2'b01);
        ena = 2'b10;
        tick('0);
        chk("irq_ena_drop", 32'(irq), 32'(0));
        iak('0);

        // IAKI without DIN is ignored
        ena = 2'b11;
        tick(2'b01);
        iaki = 1'b1;
        repeat (QBUS_RPLY_LAT) step();
        chk("noin_oe", 32'(vec_oe), 32'(0));
        chk("noin_iako", 32'(iako), 32'(0));
        chk("noin_irq", 32'(irq), 32'(1));
        iaki = 1'b0;
        repeat (QBUS_SYNC_STAGES) step();

        // Re-request in the ack cycle must not be lost
        iak(2'b01);
        tick('0);
        iak('0);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            ena = NSRC'($urandom_range(0, 3));
            set_vec(0, rand_vec());
            set_vec(1, rand_vec());
            for (int t = 0; t < 3; t++) tick(NSRC'($urandom_range(0, 3)));
            iak(NSRC'($urandom_range(0, 3)));
        end

        // Reset in the middle of a vector cycle
        ena = 2'b11;
        set_vec(0, 9'o300);
        tick(2'b01);
        din  = 1'b1;
        iaki = 1'b1;
        repeat (QBUS_RPLY_LAT) step();
        chk("pre_rst_rply", 32'(rply), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rply", 32'(rply), 32'(0));
        chk("mid_rst_oe", 32'(vec_oe), 32'(0));
        chk("mid_rst_irq", 32'(irq), 32'(0));
        m_pend    = '0;
        m_ack_now = '0;
        din       = 1'b0;
        iaki      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_irq", 32'(irq), 32'(0));
        iak('0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
